// File: rtl/fifo_drain_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_drain_arbiter_pkg                                          |
// | Brief    : Shared types for the FIFO drain arbiter (source index type,     |
// |            arbitration state encoding).                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fifo_drain_arbiter_pkg;

   // Default source count; the top derives its own index width from NUM_SRCS.
   localparam int NUM_SRCS_DEFAULT = 4;
   localparam int SRC_IDX_WIDTH    = $clog2(NUM_SRCS_DEFAULT);

   typedef logic [SRC_IDX_WIDTH-1:0] src_idx_t;

   // ARB: free round-robin scan. BURST: grant pinned to one source.
   typedef enum logic {
      ARB_STATE_ARB   = 1'b0,
      ARB_STATE_BURST = 1'b1
   } fifo_arb_state_t;

endpackage : fifo_drain_arbiter_pkg
`default_nettype wire

// File: rtl/fifo_drain_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Brief    : Combinational rotating-priority arbiter. The lowest requester   |
// |            index at or after base (wrapping) wins.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
   parameter int NUM_REQUESTERS = 4
) (
   input  logic [NUM_REQUESTERS-1:0]         req,
   input  logic [$clog2(NUM_REQUESTERS)-1:0] base,
   output logic [NUM_REQUESTERS-1:0]         grant,
   output logic [$clog2(NUM_REQUESTERS)-1:0] grant_idx,
   output logic                              grant_valid
);
   localparam int IDX_W = $clog2(NUM_REQUESTERS);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down to base so the nearest requester is the last writer.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
         // Power-of-two width makes the add wrap naturally past the top index.
         cand = base + IDX_W'(i);
         if (req[cand]) begin
            grant_idx   = cand;
            grant_valid = 1'b1;
         end
      end
      if (grant_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fifo_drain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_drain_arbiter                                              |
// | Brief    : Drains NUM_SRCS show-ahead FIFOs round-robin into one          |
// |            registered valid/ready output stage tagged with source index.   |
// |            Optional burst mode (macro FIFO_ARB_BURST_EN) keeps the grant   |
// |            on one source for up to BURST_LEN consecutive words.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fifo_drain_arbiter
   import fifo_drain_arbiter_pkg::*;
#(
   parameter int NUM_SRCS  = 4,
   parameter int WIDTH     = 64,
   parameter int BURST_LEN = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        flush_en,
   input  logic [NUM_SRCS-1:0]         src_empty,
   input  logic [NUM_SRCS*WIDTH-1:0]   src_value,
   output logic [NUM_SRCS-1:0]         src_dequeue_en,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_value,
   output logic [$clog2(NUM_SRCS)-1:0] out_src,
   input  logic                        out_ready
);
   localparam int IDX_W = $clog2(NUM_SRCS);

   // Output stage and round-robin pointer
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_value_q, out_value_d;
   logic [IDX_W-1:0] out_src_q,   out_src_d;
   logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;

   // Arbiter interface
   logic [NUM_SRCS-1:0] arb_req;
   logic [NUM_SRCS-1:0] arb_onehot;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_valid;

   // Pop decision shared by both arbitration modes
   logic                active;
   logic                can_load;
   logic                pop;
   logic [IDX_W-1:0]    pop_idx;
   logic [NUM_SRCS-1:0] pop_onehot;
   logic                ptr_load;
   logic [IDX_W-1:0]    ptr_val;

   logic [WIDTH-1:0] src_word [NUM_SRCS];

   for (genvar i = 0; i < NUM_SRCS; i++) begin : g_unpack
      assign src_word[i] = src_value[i*WIDTH +: WIDTH];
   end

   // No pops during reset or flush; a pop needs the output slot free this cycle.
   assign active   = reset_n && !flush_en;
   assign can_load = !out_valid_q || out_ready;
   assign arb_req  = ~src_empty;

   rr_arbiter #(
      .NUM_REQUESTERS (NUM_SRCS)
   ) u_rr_arbiter (
      .req         (arb_req),
      .base        (rr_ptr_q),
      .grant       (arb_onehot),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

`ifdef FIFO_ARB_BURST_EN
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   fifo_arb_state_t  state_q, state_d;
   logic [IDX_W-1:0] burst_src_q, burst_src_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   // Burst FSM state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ARB_STATE_ARB;
         burst_src_q <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         burst_src_q <= burst_src_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Burst FSM next state; the pointer only moves when a burst ends (or with single-word bursts).
   always_comb begin
      state_d     = state_q;
      burst_src_d = burst_src_q;
      burst_cnt_d = burst_cnt_q;
      ptr_load    = 1'b0;
      ptr_val     = burst_src_q + IDX_W'(1);
      cnt_inc     = burst_cnt_q + CNT_W'(1);
      if (flush_en) begin
         state_d     = ARB_STATE_ARB;
         burst_cnt_d = '0;
      end else begin
         case (state_q)
            ARB_STATE_ARB: begin
               if (pop) begin
                  if (BURST_LEN > 1) begin
                     state_d     = ARB_STATE_BURST;
                     burst_src_d = arb_idx;
                     burst_cnt_d = CNT_W'(1);
                  end else begin
                     ptr_load = 1'b1;
                     ptr_val  = arb_idx + IDX_W'(1);
                  end
               end
            end
            ARB_STATE_BURST: begin
               // A stalled output slot freezes the burst entirely.
               if (can_load) begin
                  if (src_empty[burst_src_q] || (cnt_inc == CNT_W'(BURST_LEN))) begin
                     state_d     = ARB_STATE_ARB;
                     burst_cnt_d = '0;
                     ptr_load    = 1'b1;
                  end else begin
                     burst_cnt_d = cnt_inc;
                  end
               end
            end
         endcase
      end
   end

   // Burst FSM outputs: pinned grant in BURST, arbiter grant in ARB.
   always_comb begin
      pop_onehot = '0;
      if (state_q == ARB_STATE_BURST) begin
         pop                     = active && can_load && !src_empty[burst_src_q];
         pop_idx                 = burst_src_q;
         pop_onehot[burst_src_q] = 1'b1;
      end else begin
         pop        = active && can_load && arb_valid;
         pop_idx    = arb_idx;
         pop_onehot = arb_onehot;
      end
   end
`else
   // Single-grant round-robin: every pop moves the pointer just past the winner.
   always_comb begin
      pop        = active && can_load && arb_valid;
      pop_idx    = arb_idx;
      pop_onehot = arb_onehot;
      ptr_load   = pop;
      ptr_val    = arb_idx + IDX_W'(1);
   end
`endif

   // Output stage and pointer next-state; flush drops the held word and rewinds the pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_value_d = out_value_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      if (flush_en) begin
         out_valid_d = 1'b0;
         rr_ptr_d    = '0;
      end else begin
         if (pop) begin
            out_valid_d = 1'b1;
            out_value_d = src_word[pop_idx];
            out_src_d   = pop_idx;
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (ptr_load) begin
            rr_ptr_d = ptr_val;
         end
      end
   end

   // Output stage and pointer registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         out_src_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_value_q <= out_value_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign src_dequeue_en = pop ? pop_onehot : '0;
   assign out_valid      = out_valid_q;
   assign out_value      = out_value_q;
   assign out_src        = out_src_q;

   // Pop strobe is at most one-hot and never targets an empty source.
   a_deq_onehot0  : assert property (@(posedge clk) $onehot0(src_dequeue_en));
   a_deq_nonempty : assert property (@(posedge clk) ((src_dequeue_en & src_empty) == '0));

endmodule : fifo_drain_arbiter
`default_nettype wire

// File: tb/tb_fifo_drain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fifo_drain_arbiter                                           |
// | Brief    : Directed + random bench for fifo_drain_arbiter. Source FIFOs are |
// |            queues; a queue-based reference model predicts every pop and    |
// |            the output stage. Burst steps compile with FIFO_ARB_BURST_EN.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fifo_drain_arbiter;
   localparam int NS = 4;
   localparam int W  = 64;
   localparam int BL = 4;

   logic              clk;
   logic              reset_n;
   logic              flush_en;
   logic [NS-1:0]     src_empty;
   logic [NS*W-1:0]   src_value;
   logic [NS-1:0]     src_dequeue_en;
   logic              out_valid;
   logic [W-1:0]      out_value;
   logic [1:0]        out_src;
   logic              out_ready;

   fifo_drain_arbiter #(
      .NUM_SRCS  (NS),
      .WIDTH     (W),
      .BURST_LEN (BL)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .flush_en       (flush_en),
      .src_empty      (src_empty),
      .src_value      (src_value),
      .src_dequeue_en (src_dequeue_en),
      .out_valid      (out_valid),
      .out_value      (out_value),
      .out_src        (out_src),
      .out_ready      (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Source FIFO contents (head at index 0)
   logic [W-1:0] fq [NS][$];

   // Reference model: output stage, pointer, burst owner/count
   bit           m_valid;
   logic [W-1:0] m_value;
   int           m_src;
   int           m_ptr;
   bit           m_burst;
   int           m_owner;
   int           m_cnt;

   int n_vec  = 0;
   int n_fail = 0;

`ifdef FIFO_ARB_BURST_EN
   localparam bit BURST_ON = 1'b1;
`else
   localparam bit BURST_ON = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Which source should be popped this cycle (-1: none)
   function automatic int predict();
      if (!reset_n || flush_en) return -1;
      if (m_valid && !out_ready) return -1;
      if (m_burst) return (fq[m_owner].size() != 0) ? m_owner : -1;
      for (int i = 0; i < NS; i++) begin
         int s;
         s = (m_ptr + i) % NS;
         if (fq[s].size() != 0) return s;
      end
      return -1;
   endfunction

   task automatic model_update(input int g);
      bit can;
      can = !m_valid || out_ready;
      if (!reset_n) begin
         m_valid = 0; m_value = '0; m_src = 0; m_ptr = 0; m_burst = 0; m_cnt = 0;
      end else if (flush_en) begin
         m_valid = 0; m_ptr = 0; m_burst = 0; m_cnt = 0;
      end else if (g >= 0) begin
         m_value = fq[g][0];
         m_src   = g;
         m_valid = 1;
         void'(fq[g].pop_front());
         if (!BURST_ON) begin
            m_ptr = (g + 1) % NS;
         end else if (m_burst) begin
            m_cnt++;
            if (m_cnt == BL) begin m_burst = 0; m_cnt = 0; m_ptr = (g + 1) % NS; end
         end else if (BL > 1) begin
            m_burst = 1; m_owner = g; m_cnt = 1;
         end else begin
            m_ptr = (g + 1) % NS;
         end
      end else begin
         if (out_ready) m_valid = 0;
         if (m_burst && can) begin
            m_burst = 0; m_cnt = 0; m_ptr = (m_owner + 1) % NS;
         end
      end
   endtask

   // One clock: drive inputs, check at the falling edge, advance model at the rising edge.
   task automatic tick(input bit rn, input bit fl, input bit rd);
      int g;
      logic [NS-1:0] exp_deq;
      reset_n   = rn;
      flush_en  = fl;
      out_ready = rd;
      for (int i = 0; i < NS; i++) begin
         src_empty[i] = (fq[i].size() == 0);
         src_value[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : {$urandom, $urandom};
      end
      @(negedge clk);
      g = predict();
      exp_deq = '0;
      if (g >= 0) exp_deq[g] = 1'b1;
      check("dequeue_en", 64'(src_dequeue_en), 64'(exp_deq));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
         check("out_value", out_value, m_value);
         check("out_src", 64'(out_src), 64'(m_src));
      end
      @(posedge clk);
      model_update(g);
      #1;
   endtask

   task automatic clear_fifos();
      for (int i = 0; i < NS; i++) fq[i].delete();
   endtask

   task automatic push_words(input int s, input int n);
      for (int k = 0; k < n; k++) fq[s].push_back({$urandom, $urandom});
   endtask

   initial begin
      logic [W-1:0] held;
      int got[$];
      m_valid = 0; m_value = '0; m_src = 0; m_ptr = 0; m_burst = 0; m_owner = 0; m_cnt = 0;
      reset_n = 0; flush_en = 0; out_ready = 1; src_empty = '1; src_value = '0;

      // 1: reset with all sources non-empty; first pop afterwards is src 0
      for (int i = 0; i < NS; i++) push_words(i, 3);
      repeat (3) tick(0, 0, 1);
      check("reset_out_value", out_value, 64'h0);
      check("reset_out_src", 64'(out_src), 64'h0);
      tick(1, 0, 1);
      check("first_pop_src", 64'(out_src), 64'h0);
      check("first_pop_valid", 64'(out_valid), 64'h1);

`ifndef FIFO_ARB_BURST_EN
      // 2: round-robin fairness with all sources busy, one word per cycle
      tick(0, 0, 1);
      clear_fifos();
      for (int i = 0; i < NS; i++)
         for (int k = 0; k < 4; k++) fq[i].push_back(W'(32'hA0 + i));
      for (int k = 0; k < 12; k++) begin
         tick(1, 0, 1);
         check("rr_src", 64'(out_src), 64'(k % NS));
         check("rr_value", out_value, 64'(32'hA0 + (k % NS)));
      end

      // 3: backpressure holds the output word and stops all pops
      tick(0, 0, 1);
      clear_fifos();
      for (int i = 0; i < NS; i++) push_words(i, 2);
      tick(1, 0, 1);
      held = out_value;
      for (int k = 0; k < 5; k++) begin
         tick(1, 0, 0);
         check("bp_value", out_value, held);
         check("bp_src", 64'(out_src), 64'h0);
      end
      tick(1, 0, 1);
      check("bp_resume_src", 64'(out_src), 64'h1);

      // 4: sparse requesters with wrap from pointer 2
      tick(0, 0, 1);
      clear_fifos();
      push_words(1, 1);
      tick(1, 0, 1);
      push_words(3, 3);
      push_words(1, 2);
      tick(1, 0, 1);
      check("wrap_src_a", 64'(out_src), 64'h3);
      tick(1, 0, 1);
      check("wrap_src_b", 64'(out_src), 64'h1);
      tick(1, 0, 1);
      check("wrap_src_c", 64'(out_src), 64'h3);

      // 5: flush drops the held word, pops nothing, rewinds pointer to 0
      tick(0, 0, 1);
      clear_fifos();
      push_words(2, 3);
      tick(1, 0, 0);
      check("pre_flush_valid", 64'(out_valid), 64'h1);
      tick(1, 1, 0);
      check("flush_valid", 64'(out_valid), 64'h0);
      check("flush_no_pop", 64'(fq[2].size()), 64'h2);
      push_words(0, 1);
      push_words(3, 1);
      tick(1, 0, 1);
      check("post_flush_src", 64'(out_src), 64'h0);
`else
      // 6: burst of 4 on src 0, then src 1, then a short burst ended by src 0 emptying
      tick(0, 0, 1);
      clear_fifos();
      push_words(0, 6);
      push_words(1, 2);
      for (int k = 0; k < 12; k++) begin
         tick(1, 0, 1);
         if (out_valid) got.push_back(int'(out_src));
      end
      begin
         int exp6 [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
         check("burst_count", 64'(got.size()), 64'd8);
         for (int k = 0; k < 8 && k < got.size(); k++)
            check("burst_src", 64'(got[k]), 64'(exp6[k]));
      end
`endif

      // Random traffic: sparse fills, random backpressure, occasional flush/reset
      tick(0, 0, 1);
      clear_fifos();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NS; i++)
            if (($urandom % 3 == 0) && fq[i].size() < 8) push_words(i, 1 + $urandom % 3);
         tick(($urandom % 60) != 0, ($urandom % 40) == 0, ($urandom % 4) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_fifo_drain_arbiter
`default_nettype wire
